// File: rtl/sum_avg_ctrl.sv
// Job-based accumulator: sums NUM_OPS unsigned 8-bit operands under a
// start/load/ack handshake and reports the sum plus a floored right-shifted answer.
module sum_avg_ctrl #(
  parameter int NUM_OPS = 6,
  parameter int SHIFT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        out_ack,
  output logic        out_valid,
  output logic [10:0] out,
  output logic [10:0] answer,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] acc;
  logic [3:0]  cnt;
  logic [10:0] sum_next;

  function automatic logic [10:0] floor_shift(input logic [10:0] v);
    return v >> SHIFT;
  endfunction

  assign sum_next  = acc + {3'b000, in_data};
  assign in_ready  = (state == LOAD) && !abort;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // abort has priority over start, accepts, the final operand and out_ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      answer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            acc   <= '0;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            acc <= sum_next;
            cnt <= cnt + 4'd1;
            if (cnt == LAST_IDX) begin
              out    <= sum_next;
              answer <= floor_shift(sum_next);
              state  <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
